sw_debounce_reader: RTL and testbench

//   Input-side conditioner for the 16 board slide switches: synchronises raw switch

---
 rtl/basys3_io_pkg.sv | 23 ++
 rtl/sw_debounce_bit.sv | 64 ++++++
 rtl/sw_debounce_reader.sv | 102 ++++++++++
 tb/tb_sw_debounce_reader.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/basys3_io_pkg.sv
// Package: basys3_io_pkg
// Board-level constants shared by the Basys3 switch and LED blocks, plus the
// state type of the switch snapshot channel.
//   SW_WIDTH         number of slide switches on the board
//   CLK_HZ           system clock frequency
//   DEBOUNCE_MS      time a switch level must stay stable before it is accepted
//   DEBOUNCE_CYCLES  DEBOUNCE_MS expressed in clock cycles
//   DEBOUNCE_CNT_W   smallest counter width that can reach DEBOUNCE_CYCLES
package basys3_io_pkg;

  localparam int SW_WIDTH        = 16;
  localparam int CLK_HZ          = 100_000_000;
  localparam int DEBOUNCE_MS     = 10;
  localparam int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEBOUNCE_CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

  // Snapshot channel: either nothing to offer, or one word waiting for the consumer.
  typedef enum logic {
    EVT_IDLE    = 1'b0,
    EVT_PENDING = 1'b1
  } evt_state_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// Module: sw_debounce_bit
// One switch bit: 2-FF synchroniser, stability counter, clean level and
// registered rise/fall pulses.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   sw_raw    in   asynchronous switch pin
//   sw_clean  out  debounced level
//   sw_rise   out  1-cycle pulse in the cycle sw_clean first shows 1
//   sw_fall   out  1-cycle pulse in the cycle sw_clean first shows 0
//   sw_upd    out  combinational: sw_clean takes a new value at the coming edge
module sw_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = basys3_io_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = basys3_io_pkg::DEBOUNCE_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_upd
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sw_sync;
  logic [CNT_W-1:0] cnt;

  // The counter has seen DEBOUNCE_CYCLES-1 differing cycles already; one more
  // differing cycle makes the new level official.
  assign sw_upd = (sw_sync != sw_clean) && (cnt == CNT_TERM);

  // NOTE: every register here uses <= so all of them sample the values from
  // before the edge; a blocking = would let sw_sync ripple through in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sw_sync   <= 1'b0;
      cnt       <= '0;
      sw_clean  <= 1'b0;
      sw_rise   <= 1'b0;
      sw_fall   <= 1'b0;
    end else begin
      sync_meta <= sw_raw;
      sw_sync   <= sync_meta;
      sw_rise   <= 1'b0;
      sw_fall   <= 1'b0;
      if (sw_sync == sw_clean) begin
        // Level agrees with the clean value (or a glitch went away): restart.
        cnt <= '0;
      end else if (sw_upd) begin
        sw_clean <= sw_sync;
        cnt      <= '0;
        sw_rise  <= sw_sync;
        sw_fall  <= ~sw_sync;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sw_debounce_reader.sv
// Module: sw_debounce_reader
// Conditions the board slide switches: per-bit synchronise and debounce, clean
// levels with rise/fall pulses, and a valid/ready snapshot event for every
// change of the clean word (newest word wins, overflow flag if one was lost).
// Ports:
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   sw_raw        in   [WIDTH] asynchronous switch pins
//   sw_clean      out  [WIDTH] debounced switch levels
//   sw_rise       out  [WIDTH] 1-cycle pulse per bit on clean 0->1
//   sw_fall       out  [WIDTH] 1-cycle pulse per bit on clean 1->0
//   evt_valid     out  snapshot event pending
//   evt_ready     in   consumer takes the event when evt_valid & evt_ready
//   evt_data      out  [WIDTH] sw_clean snapshot of the pending event
//   evt_overflow  out  an event was overwritten before it was accepted (sticky)
module sw_debounce_reader #(
  parameter int WIDTH           = basys3_io_pkg::SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = basys3_io_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = basys3_io_pkg::DEBOUNCE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_data,
  output logic             evt_overflow
);

  import basys3_io_pkg::*;

  logic [WIDTH-1:0] sw_upd;
  logic [WIDTH-1:0] clean_next;
  logic             chg;
  logic             accept;
  evt_state_t       state_q;
  evt_state_t       state_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .sw_raw   (sw_raw[i]),
      .sw_clean (sw_clean[i]),
      .sw_rise  (sw_rise[i]),
      .sw_fall  (sw_fall[i]),
      .sw_upd   (sw_upd[i])
    );
  end

  // The event must carry the word sw_clean is about to show, so it is built
  // from the per-bit update strobes rather than waiting a cycle for sw_clean.
  assign chg        = |sw_upd;
  assign clean_next = sw_clean ^ sw_upd;
  assign accept     = evt_valid & evt_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= EVT_IDLE;
    else     state_q <= state_d;
  end

  // Next state: a change always leaves something to offer; only an accept
  // with no concurrent change empties the channel.
  // NOTE: state_d is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EVT_IDLE:    if (chg)            state_d = EVT_PENDING;
      EVT_PENDING: if (accept && !chg) state_d = EVT_IDLE;
      default:                         state_d = EVT_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    evt_valid = (state_q == EVT_PENDING);
  end

  // Snapshot word and overflow flag. A change always overwrites the snapshot
  // (newest wins); overflow records that a pending word was dropped unseen.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_data     <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (chg) evt_data <= clean_next;
      if (evt_valid) begin
        if (accept)   evt_overflow <= 1'b0;
        else if (chg) evt_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce_reader.sv
// Directed bench for sw_debounce_reader with DEBOUNCE_CYCLES=4: reset state,
// debounce latency, glitch rejection, pulses, handshake, overflow, accept
// coinciding with a change, and reset in the middle of a debounce.
module tb_sw_debounce_reader;

  localparam int W  = 16;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         evt_valid;
  logic         evt_ready;
  logic [W-1:0] evt_data;
  logic         evt_overflow;

  int total = 0;
  int bad   = 0;

  sw_debounce_reader #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_raw       (sw_raw),
    .sw_clean     (sw_clean),
    .sw_rise      (sw_rise),
    .sw_fall      (sw_fall),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_data     (evt_data),
    .evt_overflow (evt_overflow)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] clean, input logic [W-1:0] rise,
                           input logic [W-1:0] fall, input logic valid, input logic [W-1:0] data,
                           input logic ovf);
    check({tag, ".clean"}, 32'(sw_clean), 32'(clean));
    check({tag, ".rise"},  32'(sw_rise),  32'(rise));
    check({tag, ".fall"},  32'(sw_fall),  32'(fall));
    check({tag, ".valid"}, 32'(evt_valid), 32'(valid));
    check({tag, ".data"},  32'(evt_data), 32'(data));
    check({tag, ".ovf"},   32'(evt_overflow), 32'(ovf));
  endtask

  initial begin
    // 1. Reset with all switches on, then they debounce in as one event.
    rst       = 1'b1;
    sw_raw    = 16'hFFFF;
    evt_ready = 1'b0;
    tick(2);
    check_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    tick(DC + 1);
    check("t1_not_yet.clean", 32'(sw_clean), 32'h0000);
    check("t1_not_yet.valid", 32'(evt_valid), 32'h0);
    tick(1);
    check_all("t1_accept", 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 1'b0);
    tick(1);
    check_all("t1_hold", 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0);

    // Consume the event, then bring every switch back to 0.
    evt_ready = 1'b1;
    tick(1);
    check("t1_consumed.valid", 32'(evt_valid), 32'h0);
    sw_raw = 16'h0000;
    tick(DC + 2);
    check_all("all_off", 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b0);
    tick(1);
    check_all("all_off_acc", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // 2. Glitch on bit 3: two cycles high, then low again. Counter peaks at 2.
    sw_raw = 16'h0008;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      check("glitch_hi.clean", 32'(sw_clean), 32'h0000);
    end
    sw_raw = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("glitch_lo.clean", 32'(sw_clean), 32'h0000);
      check("glitch_lo.rise",  32'(sw_rise),  32'h0000);
      check("glitch_lo.valid", 32'(evt_valid), 32'h0);
    end

    // 3. 0x0000 -> 0x0005 with the consumer ready.
    sw_raw = 16'h0005;
    tick(DC + 1);
    check("t3_not_yet.clean", 32'(sw_clean), 32'h0000);
    tick(1);
    check_all("t3_upd", 16'h0005, 16'h0005, 16'h0000, 1'b1, 16'h0005, 1'b0);
    tick(1);
    check_all("t3_acc", 16'h0005, 16'h0000, 16'h0000, 1'b0, 16'h0005, 1'b0);

    // 4. Consumer stalled: 0x0001 then 0x0003, the second overwrites the first.
    evt_ready = 1'b0;
    sw_raw    = 16'h0001;
    tick(DC + 2);
    check_all("t4_first", 16'h0001, 16'h0000, 16'h0004, 1'b1, 16'h0001, 1'b0);
    sw_raw = 16'h0003;
    tick(DC + 1);
    check_all("t4_hold", 16'h0001, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
    tick(1);
    check_all("t4_ovf", 16'h0003, 16'h0002, 16'h0000, 1'b1, 16'h0003, 1'b1);

    // 5. Accept lands on the same edge as the 0x0003 -> 0x0007 update.
    sw_raw = 16'h0007;
    tick(DC + 1);
    check_all("t5_wait", 16'h0003, 16'h0000, 16'h0000, 1'b1, 16'h0003, 1'b1);
    evt_ready = 1'b1;
    tick(1);
    check_all("t5_coincide", 16'h0007, 16'h0004, 16'h0000, 1'b1, 16'h0007, 1'b0);
    tick(1);
    check_all("t5_drain", 16'h0007, 16'h0000, 16'h0000, 1'b0, 16'h0007, 1'b0);

    // Overflow again (0x0006 then 0x0004), then raising ready clears both flags.
    evt_ready = 1'b0;
    sw_raw    = 16'h0006;
    tick(DC + 2);
    check_all("ovf2_first", 16'h0006, 16'h0000, 16'h0001, 1'b1, 16'h0006, 1'b0);
    sw_raw = 16'h0004;
    tick(DC + 2);
    check_all("ovf2_second", 16'h0004, 16'h0000, 16'h0002, 1'b1, 16'h0004, 1'b1);
    tick(2);
    check("ovf2_sticky.ovf", 32'(evt_overflow), 32'h1);
    evt_ready = 1'b1;
    tick(1);
    check_all("ovf2_clear", 16'h0004, 16'h0000, 16'h0000, 1'b0, 16'h0004, 1'b0);

    // 6. Reset while bit 0 has counted to 2.
    sw_raw = 16'h0005;
    tick(4);
    check("t6_pre.clean", 32'(sw_clean), 32'h0004);
    rst = 1'b1;
    tick(1);
    check_all("t6_reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    tick(DC + 1);
    check_all("t6_restart", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    tick(1);
    check_all("t6_accept", 16'h0005, 16'h0005, 16'h0000, 1'b1, 16'h0005, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
